// File: rtl/secadd_seq.sv
// Sequencer around a 2-share Boolean-masked ripple-carry SecAdd: gathers operands and fresh
// randomness, exposes them to the adder only once complete, captures the shares, then scrubs.
module secadd_seq #(
  parameter int unsigned K      = 16,
  parameter int unsigned RW     = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [K-1:0]  x0_i,
  input  logic [K-1:0]  x1_i,
  input  logic [K-1:0]  y0_i,
  input  logic [K-1:0]  y1_i,
  input  logic          rnd_valid_i,
  output logic          rnd_ready_o,
  input  logic [RW-1:0] rnd_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [K-1:0]  z0_o,
  output logic [K-1:0]  z1_o,
  output logic          busy_o
);

  localparam int unsigned NR     = 3 * (K - 1);
  localparam int unsigned NBEATS = (NR + RW - 1) / RW;
  localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned PIW    = $clog2(NR);

  typedef enum logic [1:0] {S_IDLE, S_RAND, S_COMPUTE, S_OUT} state_t;

  state_t         state_q, state_d;
  logic [K-1:0]   hx0_q, hx1_q, hy0_q, hy1_q, hx0_d, hx1_d, hy0_d, hy1_d;
  logic [K-1:0]   ax0_q, ax1_q, ay0_q, ay1_q, ax0_d, ax1_d, ay0_d, ay1_d;
  logic [K-1:0]   z0_q, z1_q, z0_d, z1_d;
  logic [NR-1:0]  pool_q, pool_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic [K-1:0]   sz0, sz1;

  // ISW AND of two 2-share bits; returns {c1, c0}
  function automatic logic [1:0] sec_and(input logic a0, input logic a1,
                                         input logic b0, input logic b1, input logic r);
    logic c0, c1;
    c0 = (a0 & b0) ^ r;
    c1 = (a1 & b1) ^ ((a0 & b1) ^ r) ^ (a1 & b0);
    return {c1, c0};
  endfunction

  // carry(i+1) = maj(x,y,c) as three masked ANDs; LSB carry shares are zero, final carry dropped
  function automatic logic [2*K-1:0] sec_add(input logic [K-1:0] x0, input logic [K-1:0] x1,
                                             input logic [K-1:0] y0, input logic [K-1:0] y1,
                                             input logic [K-2:0] rxy, input logic [K-2:0] rxc,
                                             input logic [K-2:0] ryc);
    logic [K-1:0] c0, c1;
    logic [1:0]   p, q, s;
    c0 = '0;
    c1 = '0;
    for (int i = 0; i < int'(K) - 1; i++) begin
      p = sec_and(x0[i], x1[i], y0[i], y1[i], rxy[i]);
      q = sec_and(x0[i], x1[i], c0[i], c1[i], rxc[i]);
      s = sec_and(y0[i], y1[i], c0[i], c1[i], ryc[i]);
      c0[i+1] = p[0] ^ q[0] ^ s[0];
      c1[i+1] = p[1] ^ q[1] ^ s[1];
    end
    return {x1 ^ y1 ^ c1, x0 ^ y0 ^ c0};
  endfunction

  assign {sz1, sz0} = sec_add(ax0_q, ax1_q, ay0_q, ay1_q,
                              pool_q[K-2:0], pool_q[2*K-3:K-1], pool_q[3*K-4:2*K-2]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      hx0_q    <= '0;
      hx1_q    <= '0;
      hy0_q    <= '0;
      hy1_q    <= '0;
      ax0_q    <= '0;
      ax1_q    <= '0;
      ay0_q    <= '0;
      ay1_q    <= '0;
      z0_q     <= '0;
      z1_q     <= '0;
      pool_q   <= '0;
      beat_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      hx0_q    <= hx0_d;
      hx1_q    <= hx1_d;
      hy0_q    <= hy0_d;
      hy1_q    <= hy1_d;
      ax0_q    <= ax0_d;
      ax1_q    <= ax1_d;
      ay0_q    <= ay0_d;
      ay1_q    <= ay1_d;
      z0_q     <= z0_d;
      z1_q     <= z1_d;
      pool_q   <= pool_d;
      beat_q   <= beat_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hx0_d    = hx0_q;
    hx1_d    = hx1_q;
    hy0_d    = hy0_q;
    hy1_d    = hy1_q;
    ax0_d    = ax0_q;
    ax1_d    = ax1_q;
    ay0_d    = ay0_q;
    ay1_d    = ay1_q;
    z0_d     = z0_q;
    z1_d     = z1_q;
    pool_d   = pool_q;
    beat_d   = beat_q;
    settle_d = settle_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          hx0_d   = x0_i;
          hx1_d   = x1_i;
          hy0_d   = y0_i;
          hy1_d   = y1_i;
          beat_d  = '0;
          state_d = S_RAND;
        end
      end
      S_RAND: begin
        if (rnd_valid_i) begin
          // surplus bits of the last beat fall outside the pool and are dropped
          for (int j = 0; j < int'(RW); j++) begin
            if (int'(beat_q) * int'(RW) + j < int'(NR))
              pool_d[PIW'(int'(beat_q) * int'(RW) + j)] = rnd_i[j];
          end
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(NBEATS - 1)) begin
            ax0_d    = hx0_q;
            ax1_d    = hx1_q;
            ay0_d    = hy0_q;
            ay1_d    = hy1_q;
            settle_d = '0;
            state_d  = S_COMPUTE;
          end
        end
      end
      S_COMPUTE: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          z0_d    = sz0;
          z1_d    = sz1;
          ax0_d   = '0;
          ax1_d   = '0;
          ay0_d   = '0;
          ay1_d   = '0;
          state_d = S_OUT;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          hx0_d   = '0;
          hx1_d   = '0;
          hy0_d   = '0;
          hy1_d   = '0;
          ax0_d   = '0;
          ax1_d   = '0;
          ay0_d   = '0;
          ay1_d   = '0;
          z0_d    = '0;
          z1_d    = '0;
          pool_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign rnd_ready_o = (state_q == S_RAND);
  assign out_valid_o = (state_q == S_OUT);
  assign busy_o      = (state_q != S_IDLE);
  assign z0_o        = z0_q;
  assign z1_o        = z1_q;

endmodule

// File: tb/tb_secadd_seq.sv
// Self-checking bench for secadd_seq: the reference is plain modular addition of the unmasked
// operands; handshakes, latency and randomness consumption are observed cycle by cycle.
module tb_secadd_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i, in_ready_o;
  logic [15:0] x0_i, x1_i, y0_i, y1_i;
  logic        rnd_valid_i, rnd_ready_o;
  logic [15:0] rnd_i;
  logic        out_valid_o, out_ready_i;
  logic [15:0] z0_o, z1_o;
  logic        busy_o;

  int tests = 0;
  int fails = 0;
  int gcyc  = 0;

  secadd_seq #(.K(16), .RW(16), .SETTLE(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .x0_i(x0_i), .x1_i(x1_i), .y0_i(y0_i), .y1_i(y1_i),
    .rnd_valid_i(rnd_valid_i), .rnd_ready_o(rnd_ready_o), .rnd_i(rnd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .z0_o(z0_o), .z1_o(z1_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) gcyc <= gcyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_sum(input logic [15:0] x0, x1, y0, y1);
    return 16'((x0 ^ x1) + (y0 ^ y1));
  endfunction

  // One full operation; cycle 0 is the cycle in which the operands are offered.
  task automatic run_op(input logic [15:0] x0, x1, y0, y1,
                        input logic [15:0] w0, w1, w2,
                        input int stall_beat, input int stall_len, input int hold_out,
                        input bit extra_in,
                        output logic [15:0] z0, output logic [15:0] z1,
                        output int lat, output int beats, output int viol, output bit tmo);
    logic [15:0] w [3];
    int cyc, stalled, held;
    bit accept, done, got;
    w[0] = w0; w[1] = w1; w[2] = w2;
    viol = 0; beats = 0; lat = -1; tmo = 0; stalled = 0; held = 0; got = 0;
    z0 = '0; z1 = '0;
    x0_i = x0; x1_i = x1; y0_i = y0; y1_i = y1;
    in_valid_i = 1'b1; rnd_valid_i = 1'b0; out_ready_i = 1'b0;
    @(posedge clk_i); #1;
    cyc = 1;
    forever begin
      if (cyc > 300) begin tmo = 1; break; end
      in_valid_i = 1'b0; rnd_valid_i = 1'b0; out_ready_i = 1'b0;
      if (beats < 3) begin
        if (rnd_ready_o !== 1'b1) viol++;
        if (beats == stall_beat && stalled < stall_len) stalled++;
        else begin rnd_valid_i = 1'b1; rnd_i = w[beats]; end
      end else begin
        // junk offered outside RAND must never be taken
        rnd_valid_i = 1'b1; rnd_i = 16'($urandom);
      end
      if (out_valid_o === 1'b1) begin
        if (!got) begin got = 1; lat = cyc; z0 = z0_o; z1 = z1_o; end
        else if (z0_o !== z0 || z1_o !== z1) viol++;
        if (in_ready_o !== 1'b0) viol++;
        if (held < hold_out) begin
          held++;
          if (extra_in) begin
            in_valid_i = 1'b1; x0_i = 16'($urandom); y0_i = 16'($urandom);
          end
        end else out_ready_i = 1'b1;
      end else if (got) viol++;
      accept = rnd_valid_i && (rnd_ready_o === 1'b1);
      done   = out_ready_i;
      @(posedge clk_i); #1;
      cyc++;
      if (accept) beats++;
      if (done) break;
    end
    in_valid_i = 1'b0; rnd_valid_i = 1'b0; out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b need 1", in_ready_o); end
    tests++; if (rnd_ready_o !== 1'b0) begin fails++; $display("FAIL reset_rnd_ready got %b need 0", rnd_ready_o); end
    tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b need 0", out_valid_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b need 0", busy_o); end
    tests++; if (z0_o !== 16'h0 || z1_o !== 16'h0) begin fails++; $display("FAIL reset_z got %h/%h need 0000/0000", z0_o, z1_o); end
  endtask

  task automatic test_basic();
    logic [15:0] z0, z1; int lat, beats, viol; bit tmo;
    run_op(16'hA5A5, 16'hB791, 16'h5A5A, 16'h55AA, 16'($urandom), 16'($urandom), 16'($urandom),
           -1, 0, 0, 0, z0, z1, lat, beats, viol, tmo);
    tests++; if (tmo) begin fails++; $display("FAIL basic_timeout got timeout need completion"); end
    tests++; if ((z0 ^ z1) !== 16'h2224) begin fails++; $display("FAIL basic_sum got %h need 2224", z0 ^ z1); end
    tests++; if (lat != 6) begin fails++; $display("FAIL basic_latency got %0d need 6", lat); end
    tests++; if (beats != 3) begin fails++; $display("FAIL basic_beats got %0d need 3", beats); end
    tests++; if (viol != 0) begin fails++; $display("FAIL basic_protocol got %0d violations need 0", viol); end
  endtask

  task automatic test_wrap();
    logic [15:0] z0, z1, r, s; int lat, beats, viol; bit tmo;
    r = 16'($urandom); s = 16'($urandom);
    run_op(r, r ^ 16'hFFFF, s, s ^ 16'h0001, 16'($urandom), 16'($urandom), 16'($urandom),
           -1, 0, 0, 0, z0, z1, lat, beats, viol, tmo);
    tests++; if ((z0 ^ z1) !== 16'h0000 || tmo) begin fails++; $display("FAIL wrap_sum got %h need 0000", z0 ^ z1); end
    run_op(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, -1, 0, 0, 0, z0, z1, lat, beats, viol, tmo);
    tests++; if (z0 !== 16'h0 || z1 !== 16'h0 || tmo) begin fails++; $display("FAIL zero_shares got %h/%h need 0000/0000", z0, z1); end
  endtask

  task automatic test_rnd_diff();
    logic [15:0] a0, a1, b0, b1, w0, w1, w2; int lat, beats, viol; bit tmo;
    w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
    run_op(16'hA5A5, 16'hB791, 16'h5A5A, 16'h55AA, w0, w1, w2, -1, 0, 0, 0, a0, a1, lat, beats, viol, tmo);
    // complementing every random bit flips the masked share of the first carry
    run_op(16'hA5A5, 16'hB791, 16'h5A5A, 16'h55AA, ~w0, ~w1, ~w2, -1, 0, 0, 0, b0, b1, lat, beats, viol, tmo);
    tests++; if ((a0 ^ a1) !== 16'h2224) begin fails++; $display("FAIL rnd_run1_sum got %h need 2224", a0 ^ a1); end
    tests++; if ((b0 ^ b1) !== 16'h2224) begin fails++; $display("FAIL rnd_run2_sum got %h need 2224", b0 ^ b1); end
    tests++; if (a0 === b0) begin fails++; $display("FAIL rnd_share_differs got %h and %h need different", a0, b0); end
  endtask

  task automatic test_stall();
    logic [15:0] z0, z1; int lat, beats, viol; bit tmo;
    run_op(16'hA5A5, 16'hB791, 16'h5A5A, 16'h55AA, 16'($urandom), 16'($urandom), 16'($urandom),
           1, 5, 0, 0, z0, z1, lat, beats, viol, tmo);
    tests++; if (lat != 11) begin fails++; $display("FAIL stall_latency got %0d need 11", lat); end
    tests++; if ((z0 ^ z1) !== 16'h2224) begin fails++; $display("FAIL stall_sum got %h need 2224", z0 ^ z1); end
    tests++; if (viol != 0 || beats != 3) begin fails++; $display("FAIL stall_protocol got viol=%0d beats=%0d need 0/3", viol, beats); end
  endtask

  task automatic test_backpressure();
    logic [15:0] z0, z1; int lat, beats, viol; bit tmo;
    run_op(16'hA5A5, 16'hB791, 16'h5A5A, 16'h55AA, 16'($urandom), 16'($urandom), 16'($urandom),
           -1, 0, 10, 1, z0, z1, lat, beats, viol, tmo);
    tests++; if (viol != 0) begin fails++; $display("FAIL bp_stable got %0d violations need 0", viol); end
    tests++; if ((z0 ^ z1) !== 16'h2224) begin fails++; $display("FAIL bp_sum got %h need 2224", z0 ^ z1); end
    tests++; if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin fails++; $display("FAIL bp_idle got in_ready=%b busy=%b need 1/0", in_ready_o, busy_o); end
    tests++;
    if (dut.pool_q !== '0 || dut.hx0_q !== '0 || dut.hx1_q !== '0 || dut.hy0_q !== '0 || dut.hy1_q !== '0 ||
        dut.ax0_q !== '0 || dut.ax1_q !== '0 || dut.ay0_q !== '0 || dut.ay1_q !== '0 || z0_o !== '0 || z1_o !== '0) begin
      fails++; $display("FAIL bp_scrub got pool=%h hx0=%h ax0=%h z0=%h need all zero", dut.pool_q, dut.hx0_q, dut.ax0_q, z0_o);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] z0, z1; int lat, beats, viol, seen; bit tmo;
    x0_i = 16'hA5A5; x1_i = 16'hB791; y0_i = 16'h5A5A; y1_i = 16'h55AA;
    in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; rnd_valid_i = 1'b1; rnd_i = 16'($urandom);
    @(posedge clk_i); #1;
    rnd_i = 16'($urandom); rst_i = 1'b1;
    #1;
    tests++; if (busy_o !== 1'b0 || rnd_ready_o !== 1'b0) begin fails++; $display("FAIL abort_async got busy=%b rnd_ready=%b need 0/0", busy_o, rnd_ready_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0; rnd_valid_i = 1'b0;
    tests++; if (dut.pool_q !== '0) begin fails++; $display("FAIL abort_pool got %h need 0", dut.pool_q); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
      @(posedge clk_i); #1;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL abort_no_output got %0d bad cycles need 0", seen); end
    run_op(16'hA5A5, 16'hB791, 16'h5A5A, 16'h55AA, 16'($urandom), 16'($urandom), 16'($urandom),
           -1, 0, 0, 0, z0, z1, lat, beats, viol, tmo);
    tests++; if ((z0 ^ z1) !== 16'h2224 || beats != 3 || lat != 6) begin
      fails++; $display("FAIL abort_next_op got sum=%h beats=%0d lat=%0d need 2224/3/6", z0 ^ z1, beats, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] z0, z1; int lat, beats, viol, t0, t1; bit tmo;
    t0 = gcyc;
    run_op(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1, 16'h2, 16'h3, -1, 0, 0, 0, z0, z1, lat, beats, viol, tmo);
    t1 = gcyc;
    run_op(16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h4, 16'h5, 16'h6, -1, 0, 0, 0, z0, z1, lat, beats, viol, tmo);
    tests++; if (t1 - t0 != 7) begin fails++; $display("FAIL b2b_period got %0d need 7", t1 - t0); end
    tests++; if ((z0 ^ z1) !== ref_sum(16'h5555, 16'h6666, 16'h7777, 16'h8888)) begin
      fails++; $display("FAIL b2b_sum got %h need %h", z0 ^ z1, ref_sum(16'h5555, 16'h6666, 16'h7777, 16'h8888));
    end
  endtask

  task automatic test_random();
    logic [15:0] x0, x1, y0, y1, z0, z1; int lat, beats, viol, sb, sl, ho, exp_lat; bit tmo;
    for (int n = 0; n < 25; n++) begin
      x0 = 16'($urandom); x1 = 16'($urandom); y0 = 16'($urandom); y1 = 16'($urandom);
      sb = int'($urandom_range(0, 3)); sl = int'($urandom_range(0, 3)); ho = int'($urandom_range(0, 3));
      exp_lat = 6 + ((sb < 3) ? sl : 0);
      run_op(x0, x1, y0, y1, 16'($urandom), 16'($urandom), 16'($urandom), sb, sl, ho, 1'($urandom),
             z0, z1, lat, beats, viol, tmo);
      tests++;
      if ((z0 ^ z1) !== ref_sum(x0, x1, y0, y1) || lat != exp_lat || beats != 3 || viol != 0 || tmo) begin
        fails++;
        $display("FAIL rand_op%0d got sum=%h lat=%0d beats=%0d viol=%0d need sum=%h lat=%0d beats=3 viol=0",
                 n, z0 ^ z1, lat, beats, viol, ref_sum(x0, x1, y0, y1), exp_lat);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; rnd_valid_i = 1'b0; out_ready_i = 1'b0;
    x0_i = '0; x1_i = '0; y0_i = '0; y1_i = '0; rnd_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;
    test_reset();
    test_basic();
    test_wrap();
    test_rnd_diff();
    test_stall();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
